// File: rtl/flash_page_reader.sv
// Reads one page of NUMBER/4 words from the on-chip flash Avalon-MM data port
// and hands each word to write_bytes, one outstanding read at a time.
module flash_page_reader #(
    parameter int NUMBER   = 256,
    parameter int FLASH_AW = 17,
    parameter int TIMEOUT  = 1023
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       go,
    input  logic [FLASH_AW-1:0]        flash_base,
    output logic                       busy,
    output logic                       finished,
    output logic                       error,
    output logic [FLASH_AW-1:0]        avm_address,
    output logic                       avm_read,
    input  logic                       avm_waitrequest,
    input  logic [31:0]                avm_readdata,
    input  logic                       avm_readdatavalid,
    output logic                       wb_start,
    output logic [$clog2(NUMBER)-1:0]  wb_addr,
    output logic [31:0]                wb_word,
    input  logic                       wb_done
);
    localparam int WORDS  = NUMBER / 4;
    localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int ADDR_W = $clog2(NUMBER);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, WB_START, WB_ARM, WB_WAIT, FINISH
    } state_t;

    state_t              state_reg, state_next;
    logic [FLASH_AW-1:0] base_reg, base_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [TCNT_W-1:0]   tcnt_reg, tcnt_next;
    logic                err_reg, err_next;
    logic [31:0]         word_reg, word_next;
    logic [IDX_W+1:0]    byte_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            base_reg  <= '0;
            idx_reg   <= '0;
            tcnt_reg  <= '0;
            err_reg   <= 1'b0;
            word_reg  <= '0;
        end else begin
            state_reg <= state_next;
            base_reg  <= base_next;
            idx_reg   <= idx_next;
            tcnt_reg  <= tcnt_next;
            err_reg   <= err_next;
            word_reg  <= word_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        base_next  = base_reg;
        idx_next   = idx_reg;
        tcnt_next  = tcnt_reg;
        err_next   = err_reg;
        word_next  = word_reg;
        busy       = (state_reg != IDLE);
        avm_read   = (state_reg == RD_REQ);
        wb_start   = (state_reg == WB_START);
        finished   = (state_reg == FINISH);
        case (state_reg)
            IDLE: begin
                if (go) begin
                    base_next  = flash_base;
                    idx_next   = '0;
                    err_next   = 1'b0;
                    state_next = RD_REQ;
                end
            end
            RD_REQ: begin
                tcnt_next = '0;
                if (!avm_waitrequest) state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (avm_readdatavalid) begin
                    word_next  = avm_readdata;
                    state_next = WB_START;
                end else if (tcnt_reg == TCNT_LAST) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    tcnt_next = tcnt_reg + 1'b1;
                end
            end
            WB_START: state_next = WB_ARM;
            // wb_done may still be high from the previous word here
            WB_ARM:   state_next = WB_WAIT;
            WB_WAIT: begin
                if (wb_done) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = FINISH;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = RD_REQ;
                    end
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign avm_address = base_reg + FLASH_AW'(idx_reg);
    assign byte_addr   = {idx_reg, 2'b00};
    assign wb_addr     = byte_addr[ADDR_W-1:0];
    assign wb_word     = word_reg;
    assign error       = err_reg;
endmodule

// File: tb/tb_flash_page_reader.sv
// Bench for flash_page_reader: Avalon slave and write_bytes models, with a
// scoreboard of expected reads and word hand-offs.
module tb_flash_page_reader;
    localparam int NUMBER   = 16;
    localparam int FLASH_AW = 17;
    localparam int TIMEOUT  = 15;
    localparam int ADDR_W   = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                go;
    logic [FLASH_AW-1:0] flash_base;
    logic                busy, finished, error;
    logic [FLASH_AW-1:0] avm_address;
    logic                avm_read;
    logic                avm_waitrequest;
    logic [31:0]         avm_readdata = '0;
    logic                avm_readdatavalid = 1'b0;
    logic                wb_start;
    logic [ADDR_W-1:0]   wb_addr;
    logic [31:0]         wb_word;
    logic                wb_done = 1'b0;

    always #5 clk = ~clk;

    flash_page_reader #(.NUMBER(NUMBER), .FLASH_AW(FLASH_AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .go(go), .flash_base(flash_base),
        .busy(busy), .finished(finished), .error(error),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .wb_start(wb_start), .wb_addr(wb_addr), .wb_word(wb_word), .wb_done(wb_done)
    );

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct { logic [16:0] addr; int len; } rd_exp_t;
    typedef struct { logic [3:0] addr; logic [31:0] word; } wb_exp_t;
    rd_exp_t rd_q[$];
    wb_exp_t wb_q[$];

    logic [16:0] cur_base = '0;
    logic [31:0] pat_key = '0;
    bit          no_resp = 1'b0;
    bit          stall_en = 1'b0;
    logic [16:0] stall_addr = '0;

    function automatic logic [31:0] pattern(logic [31:0] key, int idx);
        return (32'hA0B1C2D3 ^ key) + 32'(idx);
    endfunction

    // Avalon slave: optional 5-cycle stall on one address, data two cycles after accept
    int          cyc = 0;
    int          acc_cyc = 0;
    int          n_reads = 0;
    int          stall_cnt = 0;
    logic        pend_valid = 1'b0;
    logic [31:0] pend_data = '0;
    assign avm_waitrequest = avm_read && stall_en && (avm_address == stall_addr) && (stall_cnt < 5);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        avm_readdatavalid <= 1'b0;
        if (pend_valid) begin
            avm_readdatavalid <= 1'b1;
            avm_readdata      <= pend_data;
            pend_valid        <= 1'b0;
        end
        if (!avm_read) stall_cnt <= 0;
        else if (avm_waitrequest) stall_cnt <= stall_cnt + 1;
        if (avm_read && !avm_waitrequest) begin
            n_reads <= n_reads + 1;
            acc_cyc <= cyc + 1;
            if (!no_resp) begin
                pend_valid <= 1'b1;
                pend_data  <= pattern(pat_key, int'((avm_address - cur_base) & 17'h1FFFF));
            end
        end
    end

    // write_bytes model: done drops one cycle after start, rises ten cycles after start
    int          wcnt = 0;
    logic [3:0]  cap_addr = '0;
    logic [31:0] cap_word = '0;
    logic [7:0]  buffer [16];
    always @(posedge clk) begin
        if (wb_start) begin
            wcnt     <= 10;
            cap_addr <= wb_addr;
            cap_word <= wb_word;
        end else if (wcnt > 0) begin
            wcnt <= wcnt - 1;
            if (wcnt == 10) wb_done <= 1'b0;
            if (wcnt == 1) begin
                wb_done <= 1'b1;
                for (int j = 0; j < 4; j++) buffer[int'(cap_addr) + j] <= cap_word[8*j +: 8];
            end
        end
    end

    // Monitor: pops scoreboard on each accepted read and each wb_start
    int          run_len = 0;
    logic [16:0] run_addr = '0;
    int          n_wbstart = 0;
    int          n_fin = 0;
    always @(negedge clk) begin
        rd_exp_t re;
        wb_exp_t we;
        if (avm_read && !reset) begin
            if (run_len == 0) run_addr = avm_address;
            else chk("rd_addr_stable", avm_address, run_addr);
            run_len++;
            if (!avm_waitrequest) begin
                if (rd_q.size() == 0) chk("rd_pending", 64'(rd_q.size()), 1);
                else begin
                    re = rd_q.pop_front();
                    chk("rd_addr", avm_address, re.addr);
                    chk("rd_len", 64'(run_len), 64'(re.len));
                    $display("read  addr=%05h held=%0d cycles", avm_address, run_len);
                end
                run_len = 0;
            end
        end else begin
            run_len = 0;
        end
        if (wb_start) begin
            n_wbstart++;
            if (wb_q.size() == 0) chk("wb_pending", 64'(wb_q.size()), 1);
            else begin
                we = wb_q.pop_front();
                chk("wb_addr", wb_addr, we.addr);
                chk("wb_word", wb_word, we.word);
                $display("wb    addr=%0d word=%08h", wb_addr, wb_word);
            end
        end
        if (finished) n_fin++;
    end

    task automatic start_page(logic [16:0] base, logic [31:0] key, int nwords);
        cur_base = base;
        pat_key  = key;
        for (int i = 0; i < nwords; i++) begin
            rd_q.push_back('{17'(base + 17'(i)),
                             (stall_en && (17'(base + 17'(i)) == stall_addr)) ? 6 : 1});
            if (!no_resp) wb_q.push_back('{4'(i * 4), pattern(key, i)});
        end
        @(negedge clk);
        go = 1'b1;
        flash_base = base;
        @(negedge clk);
        go = 1'b0;
        chk("go_busy", busy, 1);
        chk("go_avm_read", avm_read, 1);
        chk("go_error_clr", error, 0);
    endtask

    task automatic wait_finish(string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (finished) seen = 1'b1;
        end
        chk({tag, "_finished"}, seen, 1);
        if (seen) begin
            chk({tag, "_error"}, error, 0);
            @(negedge clk);
            chk({tag, "_busy_after"}, busy, 0);
            chk({tag, "_fin_one"}, finished, 0);
        end
        $display("page  %s done seen=%0d", tag, seen);
    endtask

    task automatic check_page(string tag, logic [31:0] key);
        logic [31:0] w;
        for (int i = 0; i < 16; i++) begin
            w = pattern(key, i / 4);
            chk({tag, "_buf"}, buffer[i], w[8*(i%4) +: 8]);
        end
    endtask

    task automatic check_idle_outputs(string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_finished"}, finished, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_avm_read"}, avm_read, 0);
        chk({tag, "_avm_address"}, avm_address, 0);
        chk({tag, "_wb_start"}, wb_start, 0);
        chk({tag, "_wb_addr"}, wb_addr, 0);
        chk({tag, "_wb_word"}, wb_word, 0);
    endtask

    initial begin
        int reads0, wbs0, fins0;
        bit seen;
        reset = 1'b1;
        go = 1'b0;
        flash_base = '0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Ideal slave, base 0x100
        reads0 = n_reads; fins0 = n_fin;
        start_page(17'h00100, 32'h0, 4);
        wait_finish("basic");
        chk("basic_reads", 64'(n_reads - reads0), 4);
        chk("basic_fin_cnt", 64'(n_fin - fins0), 1);
        check_page("basic", 32'h0);

        // Stall on the 2nd read, a stray go while busy, stale wb_done at first arm
        stall_en = 1'b1;
        stall_addr = 17'h00201;
        reads0 = n_reads;
        start_page(17'h00200, 32'h11223344, 4);
        repeat (3) @(negedge clk);
        go = 1'b1;
        flash_base = 17'h05000;
        @(negedge clk);
        go = 1'b0;
        wait_finish("stall");
        chk("stall_reads", 64'(n_reads - reads0), 4);
        check_page("stall", 32'h11223344);
        stall_en = 1'b0;

        // Timeout: slave never returns data
        no_resp = 1'b1;
        wbs0 = n_wbstart; fins0 = n_fin;
        start_page(17'h00300, 32'h0, 1);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (error) seen = 1'b1;
        end
        chk("to_error", seen, 1);
        chk("to_latency", 64'(cyc - acc_cyc), 15);
        chk("to_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("to_no_wbstart", 64'(n_wbstart - wbs0), 0);
        chk("to_no_finish", 64'(n_fin - fins0), 0);
        chk("to_error_sticky", error, 1);
        $display("tmo   error=%0d after %0d cycles", error, cyc - acc_cyc);
        no_resp = 1'b0;

        // Address wrap; the go also clears the sticky error
        start_page(17'h1FFFE, 32'h55AA55AA, 4);
        wait_finish("wrap");
        check_page("wrap", 32'h55AA55AA);

        // Reset in WB_WAIT of word 2
        wbs0 = n_wbstart;
        start_page(17'h00400, 32'h0F0F0F0F, 4);
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (n_wbstart - wbs0 >= 3) seen = 1'b1;
        end
        chk("rst_reach_word2", seen, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_idle_outputs("midrst");
        rd_q.delete();
        wb_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wbs0 = n_wbstart; reads0 = n_reads;
        repeat (30) @(negedge clk);
        chk("rst_no_wbstart", 64'(n_wbstart - wbs0), 0);
        chk("rst_no_reads", 64'(n_reads - reads0), 0);
        $display("reset mid-page, idle busy=%0d", busy);
        start_page(17'h00500, 32'hCAFEF00D, 4);
        wait_finish("restart");
        check_page("restart", 32'hCAFEF00D);

        chk("rd_q_drained", 64'(rd_q.size()), 0);
        chk("wb_q_drained", 64'(wb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
